// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the canonical NOP, the fetch FSM encoding and the IF/ID pipeline record.
// Purely declarative; no logic lives here apart from a trivial PC increment helper.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- what the decoder sees whenever IF/ID holds no real instruction
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

    // Contents of IF/ID after reset and whenever a bubble is inserted.
    localparam if_id_t IF_ID_BUBBLE = '{1'b0, NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};

    // Sequential successor; wraps modulo 2^XLEN by construction.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a new record, holds it, or replaces it with a bubble.
// Latency: one cycle from d_i to q_o.  Ports: clk, rst_n, load_i, bubble_i, d_i (if_id_t), q_o (if_id_t).
// Backpressure: with neither load_i nor bubble_i asserted the register holds (stall).
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Bubble wins over load so a squash can never be overridden by a late fetch.
    always_comb begin
        if_id_d = if_id_q;
        if (bubble_i) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (load_i) begin
            if_id_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign q_o = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, BOOT/RUN/FAULT FSM, IF/ID register.
// Latency: word at address A appears on if_id_* one cycle after imem_addr_o==A; memory read is combinational.
// Backpressure: stall_i freezes PC and IF/ID; redirect_i overrides stall and squashes the in-flight word.
// Ports: clk/rst_n (sync active-low); stall_i, redirect_i, redirect_pc_i from hazard/execute;
// imem_addr_o/imem_instr_i to instruction memory; if_id_* pipeline outputs; fetch_fault_o sticky fault.
// Optional macro FETCH_ADDR_CHECK_EN: every new PC is checked against the instruction window;
// an illegal candidate freezes fetch in FAULT until reset. Without it fetch_fault_o is constant 0.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      DATA_WIDTH = 32,
    parameter logic [31:0]      RESET_PC   = 32'hBFC0_0000,
    parameter int unsigned      IMEM_SIZE  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    output logic                  if_id_valid_o,
    output logic [DATA_WIDTH-1:0] if_id_instr_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_o,
    output logic [DATA_WIDTH-1:0] if_id_pc4_o,
    output logic                  fetch_fault_o
);

    // The window bound is only meaningful for a word-aligned, non-empty window.
    if ((IMEM_SIZE < 4) || ((IMEM_SIZE % 4) != 0)) begin : g_bad_imem_size
        $error("fetch_stage: IMEM_SIZE must be a positive multiple of 4");
    end

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] cand_pc;
    logic            cand_bad;
    logic            ifid_load;
    logic            ifid_bubble;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [XLEN-1:0] WINDOW_LAST = RESET_PC + 32'(IMEM_SIZE) - 32'd4;

    logic fault_q, fault_d;

    function automatic logic addr_bad(input logic [XLEN-1:0] a);
        return (a[1:0] != 2'b00) || (a < RESET_PC) || (a > WINDOW_LAST);
    endfunction
`endif

    assign pc_plus4 = pc_inc(pc_q);
    // Redirect target is taken as-is (no realignment); otherwise the sequential successor.
    assign cand_pc  = redirect_i ? redirect_pc_i : pc_plus4;

`ifdef FETCH_ADDR_CHECK_EN
    assign cand_bad = addr_bad(cand_pc);
`else
    assign cand_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = '{1'b1, imem_instr_i, pc_q, pc_plus4};
`ifdef FETCH_ADDR_CHECK_EN
        fault_d     = fault_q;
`endif
        unique case (state_q)
            BOOT: begin
                // PC already holds RESET_PC; spend one cycle letting memory see it.
                state_d     = RUN;
                ifid_bubble = 1'b1;
            end
            RUN: begin
                if (redirect_i || !stall_i) begin
                    // Redirect squashes the word fetched this cycle. On a plain advance the
                    // current word is legitimate (pc_q passed its own check) and is delivered
                    // even if its successor turns out to be illegal.
                    ifid_load   = !redirect_i;
                    ifid_bubble = redirect_i;
                    if (cand_bad) begin
                        state_d = FAULT;
`ifdef FETCH_ADDR_CHECK_EN
                        fault_d = 1'b1;
`endif
                    end else begin
                        pc_d = cand_pc;
                    end
                end
            end
            default: begin
                // FAULT: fetch is dead until reset; keep IF/ID empty.
                ifid_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
`ifdef FETCH_ADDR_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef FETCH_ADDR_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = ifid_q.valid;
    assign if_id_instr_o = ifid_q.instr;
    assign if_id_pc_o    = ifid_q.pc;
    assign if_id_pc4_o   = ifid_q.pc4;

`ifdef FETCH_ADDR_CHECK_EN
    assign fetch_fault_o = fault_q;
`else
    assign fetch_fault_o = 1'b0;
`endif

endmodule
